// File: rtl/alu_arb_pkg.sv
// -----------------------------------------------------------------------------
// alu_arb_pkg
// Shared definitions for the ALU share arbiter:
//   - slot_state_t : per-requester slot state (FREE / ISSUE / HOLD)
//   - req_id_t     : requester index (0 = EX-stage ops, 1 = addr/branch helper)
//   - DATA_W_DEF / FUNC_W_DEF : default operand and function-code widths
//   - ALU_* : function codes, kept numerically identical to the core's
//             Parameters.v macros so the bench and the core agree. The arbiter
//             never decodes them; they are passed through unchecked.
// -----------------------------------------------------------------------------
package alu_arb_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int FUNC_W_DEF = 4;

   typedef enum logic [1:0] {
      SLOT_FREE  = 2'd0,
      SLOT_ISSUE = 2'd1,
      SLOT_HOLD  = 2'd2
   } slot_state_t;

   typedef logic [0:0] req_id_t;

   localparam logic [FUNC_W_DEF-1:0] ALU_ADD  = 4'd0;
   localparam logic [FUNC_W_DEF-1:0] ALU_SUB  = 4'd1;
   localparam logic [FUNC_W_DEF-1:0] ALU_SLL  = 4'd2;
   localparam logic [FUNC_W_DEF-1:0] ALU_SLT  = 4'd3;
   localparam logic [FUNC_W_DEF-1:0] ALU_SLTU = 4'd4;
   localparam logic [FUNC_W_DEF-1:0] ALU_XOR  = 4'd5;
   localparam logic [FUNC_W_DEF-1:0] ALU_SRL  = 4'd6;
   localparam logic [FUNC_W_DEF-1:0] ALU_SRA  = 4'd7;
   localparam logic [FUNC_W_DEF-1:0] ALU_OR   = 4'd8;
   localparam logic [FUNC_W_DEF-1:0] ALU_AND  = 4'd9;

endpackage

// File: rtl/alu_arb_slot.sv
// -----------------------------------------------------------------------------
// alu_arb_slot
// One requester's slot: a three-state FSM plus the result buffer.
//   FREE  -> ISSUE on accept
//   ISSUE -> HOLD after exactly one cycle, capturing alu_out on that edge
//   HOLD  -> FREE when the response handshake completes
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   accept        : this requester was granted this cycle
//   cap_en        : the issue register belongs to this slot (capture qualifier)
//   alu_out       : combinational result from the shared ALU
//   rsp_ready     : consumer takes the result
//   is_free       : slot can take a new request
//   is_issue      : slot's op is on the ALU this cycle
//   rsp_valid     : result available (slot in HOLD)
//   rsp_data      : captured result, stable while HOLD
// -----------------------------------------------------------------------------
module alu_arb_slot
   import alu_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              accept,
   input  logic              cap_en,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              rsp_ready,
   output logic              is_free,
   output logic              is_issue,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data
);

   slot_state_t       state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      case (state_q)
         SLOT_FREE: begin
            if (accept) state_d = SLOT_ISSUE;
         end
         SLOT_ISSUE: begin
            state_d = SLOT_HOLD;
            if (cap_en) data_d = alu_out;
         end
         SLOT_HOLD: begin
            // rsp_valid is implied by HOLD, so rsp_ready alone completes it
            if (rsp_ready) state_d = SLOT_FREE;
         end
         default: state_d = SLOT_FREE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SLOT_FREE;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   assign is_free   = (state_q == SLOT_FREE);
   assign is_issue  = (state_q == SLOT_ISSUE);
   assign rsp_valid = (state_q == SLOT_HOLD);
   assign rsp_data  = data_q;

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between two requesters (port 0: EX-stage
// integer ops, port 1: address/branch-target helper). Round-robin grant,
// a one-deep issue register driving the ALU, and one result slot per
// requester with a valid/ready response handshake. No arithmetic here.
//
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   reqN_valid/ready/op1/op2/func    : request channel N (N = 0, 1)
//   rspN_valid/ready/data            : response channel N
//   alu_op1/alu_op2/alu_func         : to the shared ALU (zero when idle)
//   alu_out                          : combinational result from the ALU
//   stat_grant0/1, stat_conflict     : only when ALU_ARB_STATS_EN is defined;
//                                      accept counts and contested-cycle count
//
// Build option: define ALU_ARB_STATS_EN to add the statistics counters.
//
// Timing: accept on edge N, ALU driven in cycle N+1, rsp_valid from N+2.
// A slot freed by a handshake is eligible only the following cycle, so there
// is no combinational path from rsp_ready to req_ready.
// -----------------------------------------------------------------------------
module alu_share_arbiter
   import alu_arb_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int FUNC_W = FUNC_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_op1,
   input  logic [DATA_W-1:0] req0_op2,
   input  logic [FUNC_W-1:0] req0_func,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_op1,
   input  logic [DATA_W-1:0] req1_op2,
   input  logic [FUNC_W-1:0] req1_func,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_data,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_data,
   output logic [DATA_W-1:0] alu_op1,
   output logic [DATA_W-1:0] alu_op2,
   output logic [FUNC_W-1:0] alu_func,
   input  logic [DATA_W-1:0] alu_out
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [31:0]       stat_grant0,
   output logic [31:0]       stat_grant1,
   output logic [31:0]       stat_conflict
`endif
);

   // Vectorised view of the two channels so per-requester logic is indexable
   logic [1:0]        req_valid, rsp_ready_v, rsp_valid_v;
   logic [1:0]        slot_free, slot_issue, eligible, grant;
   logic [DATA_W-1:0] req_op1 [2];
   logic [DATA_W-1:0] req_op2 [2];
   logic [FUNC_W-1:0] req_func [2];
   logic [DATA_W-1:0] rsp_data_v [2];

   assign req_valid   = {req1_valid, req0_valid};
   assign rsp_ready_v = {rsp1_ready, rsp0_ready};
   assign req_op1[0]  = req0_op1;
   assign req_op1[1]  = req1_op1;
   assign req_op2[0]  = req0_op2;
   assign req_op2[1]  = req1_op2;
   assign req_func[0] = req0_func;
   assign req_func[1] = req1_func;

   // Grant and round-robin pointer
   req_id_t           rr_ptr_q, rr_ptr_d;
   logic              accept;
   req_id_t           win_id;

   // rst_n gates eligibility so req*_ready also reads 0 while reset is held
   assign eligible = req_valid & slot_free & {2{rst_n}};

   always_comb begin
      grant    = eligible;
      rr_ptr_d = rr_ptr_q;
      if (&eligible) begin
         grant           = '0;
         grant[rr_ptr_q] = 1'b1;
         rr_ptr_d        = ~rr_ptr_q;   // loser gets priority next time
      end
   end

   assign accept     = |grant;
   assign win_id     = grant[1];
   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   // Issue register
   req_id_t           iss_id_q, iss_id_d;
   logic [DATA_W-1:0] iss_op1_q, iss_op1_d;
   logic [DATA_W-1:0] iss_op2_q, iss_op2_d;
   logic [FUNC_W-1:0] iss_func_q, iss_func_d;
   logic              iss_valid;

   always_comb begin
      iss_id_d   = iss_id_q;
      iss_op1_d  = iss_op1_q;
      iss_op2_d  = iss_op2_q;
      iss_func_d = iss_func_q;
      if (accept) begin
         iss_id_d   = win_id;
         iss_op1_d  = req_op1[win_id];
         iss_op2_d  = req_op2[win_id];
         iss_func_d = req_func[win_id];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q   <= '0;
         iss_id_q   <= '0;
         iss_op1_q  <= '0;
         iss_op2_q  <= '0;
         iss_func_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         iss_id_q   <= iss_id_d;
         iss_op1_q  <= iss_op1_d;
         iss_op2_q  <= iss_op2_d;
         iss_func_q <= iss_func_d;
      end
   end

   // At most one slot can be in ISSUE, since only one accept happens per cycle
   assign iss_valid = |slot_issue;
   assign alu_op1   = iss_valid ? iss_op1_q  : '0;
   assign alu_op2   = iss_valid ? iss_op2_q  : '0;
   assign alu_func  = iss_valid ? iss_func_q : '0;

   // Per-requester slots
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_slot
         alu_arb_slot #(.DATA_W(DATA_W)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .accept    (grant[gi]),
            .cap_en    (iss_id_q == req_id_t'(gi)),
            .alu_out   (alu_out),
            .rsp_ready (rsp_ready_v[gi]),
            .is_free   (slot_free[gi]),
            .is_issue  (slot_issue[gi]),
            .rsp_valid (rsp_valid_v[gi]),
            .rsp_data  (rsp_data_v[gi])
         );
      end
   endgenerate

   assign rsp0_valid = rsp_valid_v[0];
   assign rsp1_valid = rsp_valid_v[1];
   assign rsp0_data  = rsp_data_v[0];
   assign rsp1_data  = rsp_data_v[1];

`ifdef ALU_ARB_STATS_EN
   logic [31:0] stat_grant0_q, stat_grant0_d;
   logic [31:0] stat_grant1_q, stat_grant1_d;
   logic [31:0] stat_conflict_q, stat_conflict_d;

   // Counters wrap naturally at 2^32
   always_comb begin
      stat_grant0_d   = stat_grant0_q   + {31'd0, grant[0]};
      stat_grant1_d   = stat_grant1_q   + {31'd0, grant[1]};
      stat_conflict_d = stat_conflict_q + {31'd0, &eligible};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_grant0_q   <= '0;
         stat_grant1_q   <= '0;
         stat_conflict_q <= '0;
      end else begin
         stat_grant0_q   <= stat_grant0_d;
         stat_grant1_q   <= stat_grant1_d;
         stat_conflict_q <= stat_conflict_d;
      end
   end

   assign stat_grant0   = stat_grant0_q;
   assign stat_grant1   = stat_grant1_q;
   assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
// Directed bench for alu_share_arbiter with a behavioural ALU model hanging
// off alu_op1/alu_op2/alu_func. Statistics checks are compiled in when
// ALU_ARB_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;
   import alu_arb_pkg::*;

   localparam int DW = 32;
   localparam int FW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [DW-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
   logic [FW-1:0] req0_func, req1_func;
   logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [DW-1:0] rsp0_data, rsp1_data;
   logic [DW-1:0] alu_op1, alu_op2, alu_out;
   logic [FW-1:0] alu_func;
`ifdef ALU_ARB_STATS_EN
   logic [31:0]   stat_grant0, stat_grant1, stat_conflict;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.DATA_W(DW), .FUNC_W(FW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op1   (req0_op1),
      .req0_op2   (req0_op2),
      .req0_func  (req0_func),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op1   (req1_op1),
      .req1_op2   (req1_op2),
      .req1_func  (req1_func),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (rsp0_ready),
      .rsp0_data  (rsp0_data),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (rsp1_ready),
      .rsp1_data  (rsp1_data),
      .alu_op1    (alu_op1),
      .alu_op2    (alu_op2),
      .alu_func   (alu_func),
      .alu_out    (alu_out)
`ifdef ALU_ARB_STATS_EN
      ,
      .stat_grant0   (stat_grant0),
      .stat_grant1   (stat_grant1),
      .stat_conflict (stat_conflict)
`endif
   );

   // Behavioural shared ALU (unknown codes give 0)
   always_comb begin
      alu_out = '0;
      case (alu_func)
         ALU_ADD:  alu_out = alu_op1 + alu_op2;
         ALU_SUB:  alu_out = alu_op1 - alu_op2;
         ALU_SLL:  alu_out = alu_op1 << alu_op2[4:0];
         ALU_SLT:  alu_out = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
         ALU_SLTU: alu_out = {31'd0, alu_op1 < alu_op2};
         ALU_XOR:  alu_out = alu_op1 ^ alu_op2;
         ALU_SRL:  alu_out = alu_op1 >> alu_op2[4:0];
         ALU_SRA:  alu_out = $unsigned($signed(alu_op1) >>> alu_op2[4:0]);
         ALU_OR:   alu_out = alu_op1 | alu_op2;
         ALU_AND:  alu_out = alu_op1 & alu_op2;
         default:  alu_out = '0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " req0_ready"}, {31'd0, req0_ready}, 32'd0);
      chk({tag, " req1_ready"}, {31'd0, req1_ready}, 32'd0);
      chk({tag, " rsp0_valid"}, {31'd0, rsp0_valid}, 32'd0);
      chk({tag, " rsp1_valid"}, {31'd0, rsp1_valid}, 32'd0);
      chk({tag, " rsp0_data"},  rsp0_data, 32'd0);
      chk({tag, " rsp1_data"},  rsp1_data, 32'd0);
      chk({tag, " alu_op1"},    alu_op1, 32'd0);
      chk({tag, " alu_op2"},    alu_op2, 32'd0);
      chk({tag, " alu_func"},   {28'd0, alu_func}, 32'd0);
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      req0_valid = 0; req0_op1 = 0; req0_op2 = 0; req0_func = 0;
      req1_valid = 0; req1_op1 = 0; req1_op2 = 0; req1_func = 0;
      rsp0_ready = 1; rsp1_ready = 1;
      #2 rst_n = 1'b0;
      tick();
      tick();
      chk_all_zero("reset");
      rst_n = 1'b1;

      // ---- Single req0 ADD 5+7 ----
      req0_valid = 1; req0_op1 = 5; req0_op2 = 7; req0_func = ALU_ADD;
      #1;
      chk("A.c0 req0_ready", {31'd0, req0_ready}, 32'd1);
      chk("A.c0 req1_ready", {31'd0, req1_ready}, 32'd0);
      $display("txn: req0 ADD 5+7");
      tick(); req0_valid = 0; #1;
      chk("A.c1 alu_func", {28'd0, alu_func}, {28'd0, ALU_ADD});
      chk("A.c1 alu_op1", alu_op1, 32'd5);
      chk("A.c1 alu_op2", alu_op2, 32'd7);
      chk("A.c1 rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      tick(); #1;
      chk("A.c2 rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      chk("A.c2 rsp0_data", rsp0_data, 32'd12);
      tick(); #1;
      chk("A.c3 rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      req0_valid = 1; #1;
      chk("A.c3 slot free", {31'd0, req0_ready}, 32'd1);
      req0_valid = 0; #1;

      // ---- Idle bus ----
      for (int i = 0; i < 5; i++) begin
         tick(); #1;
         chk("idle alu_op1", alu_op1, 32'd0);
         chk("idle alu_op2", alu_op2, 32'd0);
         chk("idle alu_func", {28'd0, alu_func}, 32'd0);
         chk("idle ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      end

      // ---- Both valid from reset: SUB 10-3, XOR F0^0F ----
      tick();
      reset_pulse();
      req0_valid = 1; req0_op1 = 10;    req0_op2 = 3;     req0_func = ALU_SUB;
      req1_valid = 1; req1_op1 = 'hF0;  req1_op2 = 'h0F;  req1_func = ALU_XOR;
      #1;
      chk("B.c0 grant0", {30'd0, req1_ready, req0_ready}, 32'd1);
      $display("txn: req0 SUB 10-3 (contested, rr=0)");
      tick(); req0_valid = 0; #1;
      chk("B.c1 grant1", {30'd0, req1_ready, req0_ready}, 32'd2);
      chk("B.c1 alu_func", {28'd0, alu_func}, {28'd0, ALU_SUB});
      $display("txn: req1 XOR F0^0F");
      tick(); req1_valid = 0; #1;
      chk("B.c2 rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      chk("B.c2 rsp0_data", rsp0_data, 32'd7);
      chk("B.c2 rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
      tick(); #1;
      chk("B.c3 rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      chk("B.c3 rsp1_data", rsp1_data, 32'hFF);
      chk("B.c3 rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
      tick();
      // Second contest: rr_ptr now points at requester 1
      req0_valid = 1; req0_op1 = 'hFF; req0_op2 = 'h0F; req0_func = ALU_AND;
      req1_valid = 1; req1_op1 = 1;    req1_op2 = 1;    req1_func = ALU_ADD;
      #1;
      chk("B.c4 rr grant1", {30'd0, req1_ready, req0_ready}, 32'd2);
      $display("txn: req1 ADD 1+1 (contested, rr=1)");
      tick(); req1_valid = 0; #1;
      chk("B.c5 grant0", {30'd0, req1_ready, req0_ready}, 32'd1);
      $display("txn: req0 AND FF&0F");
      tick(); req0_valid = 0; #1;
      chk("B.c6 rsp1_data", rsp1_data, 32'd2);
      chk("B.c6 rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      tick(); #1;
      chk("B.c7 rsp0_data", rsp0_data, 32'h0F);
      chk("B.c7 rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
      tick();

      // ---- rsp1 back-pressure: SLTU 1<2, rsp1_ready low 10 cycles ----
      rsp1_ready = 0;
      req1_valid = 1; req1_op1 = 1; req1_op2 = 2; req1_func = ALU_SLTU;
      #1;
      chk("C.c0 req1_ready", {31'd0, req1_ready}, 32'd1);
      $display("txn: req1 SLTU 1<2");
      tick();
      req1_op1 = 9; req1_op2 = 4; req1_func = ALU_SUB;   // next op, held
      #1;
      chk("C.c1 req1_ready", {31'd0, req1_ready}, 32'd0);
      chk("C.c1 alu_func", {28'd0, alu_func}, {28'd0, ALU_SLTU});
      tick();
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("C.hold rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
         chk("C.hold rsp1_data", rsp1_data, 32'd1);
         chk("C.hold req1_ready", {31'd0, req1_ready}, 32'd0);
         if (i == 0) begin
            req0_valid = 1; req0_op1 = 3; req0_op2 = 4; req0_func = ALU_ADD;
            #1;
            chk("C.req0_ready", {31'd0, req0_ready}, 32'd1);
            $display("txn: req0 ADD 3+4 during rsp1 stall");
         end
         if (i == 1) chk("C.req0 alu_func", {28'd0, alu_func}, {28'd0, ALU_ADD});
         if (i == 2) begin
            chk("C.rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
            chk("C.rsp0_data", rsp0_data, 32'd7);
         end
         tick();
         if (i == 0) req0_valid = 0;
      end
      rsp1_ready = 1; #1;
      chk("C.c12 rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      chk("C.c12 req1_ready", {31'd0, req1_ready}, 32'd0);
      tick(); #1;
      chk("C.c13 req1_ready", {31'd0, req1_ready}, 32'd1);
      $display("txn: req1 SUB 9-4 after stall");
      tick(); req1_valid = 0;
      tick(); #1;
      chk("C.c15 rsp1_data", rsp1_data, 32'd5);
      chk("C.c15 rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
      tick();

      // ---- Reset mid-operation: SLL 1<<4 ----
      req0_valid = 1; req0_op1 = 1; req0_op2 = 4; req0_func = ALU_SLL;
      #1;
      chk("D.c0 req0_ready", {31'd0, req0_ready}, 32'd1);
      $display("txn: req0 SLL 1<<4 (to be discarded)");
      tick(); req0_valid = 0; #1;
      chk("D.c1 alu_func", {28'd0, alu_func}, {28'd0, ALU_SLL});
      rst_n = 0; #1;
      chk_all_zero("D.async");
      tick();
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("D.post rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
         chk("D.post alu_func", {28'd0, alu_func}, 32'd0);
         tick();
      end

`ifdef ALU_ARB_STATS_EN
      // ---- Statistics: 4 contested rounds + 2 solo req0 ----
      reset_pulse();
      #1;
      chk("S.reset conflict", stat_conflict, 32'd0);
      chk("S.reset grant0", stat_grant0, 32'd0);
      for (int r = 0; r < 4; r++) begin
         req0_valid = 1; req0_op1 = r; req0_op2 = 1; req0_func = ALU_ADD;
         req1_valid = 1; req1_op1 = r; req1_op2 = 2; req1_func = ALU_ADD;
         #1;
         chk("S.contest grant", {30'd0, req1_ready, req0_ready},
             (r % 2 == 0) ? 32'd1 : 32'd2);
         $display("txn: contested round %0d", r);
         tick();
         req0_valid = 0; req1_valid = 0;
         tick();
         tick();
      end
      for (int s = 0; s < 2; s++) begin
         req0_valid = 1; req0_op1 = s; req0_op2 = 3; req0_func = ALU_OR;
         #1;
         chk("S.solo req0_ready", {31'd0, req0_ready}, 32'd1);
         $display("txn: solo req0 %0d", s);
         tick();
         req0_valid = 0;
         tick();
         tick();
      end
      #1;
      chk("S.conflict", stat_conflict, 32'd4);
      chk("S.grant0", stat_grant0, 32'd4);
      chk("S.grant1", stat_grant1, 32'd2);
      chk("S.grant sum", stat_grant0 + stat_grant1, 32'd6);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
